// File: rtl/slip_pkg.sv
// Shared SLIP (RFC 1055) byte constants and FSM state type.
// Used by the RX deframer and the future TX framer.
package slip_pkg;

  localparam logic [7:0] SLIP_END     = 8'hC0;
  localparam logic [7:0] SLIP_ESC     = 8'hDB;
  localparam logic [7:0] SLIP_ESC_END = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_ESC  = 2'd1,
    ST_DROP = 2'd2
  } slip_state_e;

endpackage

// File: rtl/slip_out_stage.sv
// Registered AXI-stream output slot carrying tdata+tlast.
// Holds its payload stable while valid and not ready.
module slip_out_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       last_i,
  output logic       ready_o,
  output logic [7:0] m_tdata_o,
  output logic       m_tvalid_o,
  output logic       m_tlast_o,
  input  logic       m_tready_i
);

  logic [7:0] data_q, data_d;
  logic       last_q, last_d;
  logic       valid_q, valid_d;

  // The slot may be refilled in the same cycle its current byte is taken.
  assign ready_o = !valid_q || m_tready_i;

  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (push_i) begin
      data_d  = data_i;
      last_d  = last_i;
      valid_d = 1'b1;
    end else if (m_tready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign m_tdata_o  = data_q;
  assign m_tvalid_o = valid_q;
  assign m_tlast_o  = last_q;

endmodule

// File: rtl/uart_slip_deframer.sv
// SLIP receive deframer: un-escapes, strips END, marks tlast on the final byte.
// Optional saturating error counter enabled by SLIP_DEFRAMER_ERR_CNT_EN.
module uart_slip_deframer
  import slip_pkg::*;
#(
  parameter int MAX_LEN = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        frame_err
`ifdef SLIP_DEFRAMER_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

  slip_state_e   state_q, state_d;
  logic [7:0]    hold_data_q, hold_data_d;
  logic          hold_valid_q, hold_valid_d;
  logic [CW-1:0] len_q, len_d;
  logic          err_q, err_d;
  logic          accept, push, push_last, is_data, close;
  logic [7:0]    data_byte;

  assign accept = s_tvalid && s_tready;

  // Classify the accepted raw byte, then apply the data/close effects on the hold register.
  always_comb begin
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    len_d        = len_q;
    err_d        = 1'b0;
    push         = 1'b0;
    push_last    = 1'b0;
    is_data      = 1'b0;
    close        = 1'b0;
    data_byte    = s_tdata;
    if (accept) begin
      case (state_q)
        ST_DATA: begin
          if (s_tdata == SLIP_END)      close   = 1'b1;
          else if (s_tdata == SLIP_ESC) state_d = ST_ESC;
          else                          is_data = 1'b1;
        end
        ST_ESC: begin
          state_d = ST_DATA;
          if (s_tdata == SLIP_ESC_END) begin
            is_data   = 1'b1;
            data_byte = SLIP_END;
          end else if (s_tdata == SLIP_ESC_ESC) begin
            is_data   = 1'b1;
            data_byte = SLIP_ESC;
          end else if (s_tdata == SLIP_END) begin
            err_d = 1'b1;
            close = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DROP;
          end
        end
        ST_DROP: begin
          if (s_tdata == SLIP_END) begin
            close   = 1'b1;
            state_d = ST_DATA;
          end
        end
        default: state_d = ST_DATA;
      endcase
    end
    if (is_data) begin
      if (len_q == MAX_CNT) begin
        err_d   = 1'b1;
        state_d = ST_DROP;
      end else begin
        push         = hold_valid_q;
        hold_data_d  = data_byte;
        hold_valid_d = 1'b1;
        len_d        = len_q + CW'(1);
      end
    end
    if (close) begin
      push         = hold_valid_q;
      push_last    = 1'b1;
      hold_valid_d = 1'b0;
      len_d        = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_DATA;
      hold_data_q  <= 8'h00;
      hold_valid_q <= 1'b0;
      len_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      len_q        <= len_d;
      err_q        <= err_d;
    end
  end

  assign frame_err = err_q;

`ifdef SLIP_DEFRAMER_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= 16'h0000;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

  slip_out_stage u_out (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .data_i     (hold_data_q),
    .last_i     (push_last),
    .ready_o    (s_tready),
    .m_tdata_o  (m_tdata),
    .m_tvalid_o (m_tvalid),
    .m_tlast_o  (m_tlast),
    .m_tready_i (m_tready)
  );

endmodule

// File: tb/tb_uart_slip_deframer.sv
// Self-checking bench for uart_slip_deframer (MAX_LEN=4 so the length limit is reachable).
// Covers SLIP_DEFRAMER_ERR_CNT_EN builds as well as the default build.
module tb_uart_slip_deframer;

  localparam int MAX_LEN = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;
  logic       frame_err;
`ifdef SLIP_DEFRAMER_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int errSeen  = 0;
  int mErrs    = 0;
  bit mEsc     = 1'b0;
  bit mDrop    = 1'b0;
  logic [7:0] frameQ [$];
  logic [8:0] expQ [$];
  logic [8:0] recvLog [$];

  always #5 clk = ~clk;

  uart_slip_deframer #(.MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .frame_err (frame_err)
`ifdef SLIP_DEFRAMER_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: collect a whole frame, release it with tlast on its final byte at END.
  task automatic modelClose();
    for (int i = 0; i < frameQ.size(); i++)
      expQ.push_back({(i == frameQ.size() - 1), frameQ[i]});
    frameQ.delete();
  endtask

  task automatic modelData(input logic [7:0] d);
    if (frameQ.size() == MAX_LEN) begin
      mErrs++;
      mDrop = 1'b1;
    end else begin
      frameQ.push_back(d);
    end
  endtask

  task automatic modelByte(input logic [7:0] b);
    if (mDrop) begin
      if (b == 8'hC0) begin
        modelClose();
        mDrop = 1'b0;
      end
    end else if (mEsc) begin
      mEsc = 1'b0;
      if (b == 8'hDC)      modelData(8'hC0);
      else if (b == 8'hDD) modelData(8'hDB);
      else if (b == 8'hC0) begin
        mErrs++;
        modelClose();
      end else begin
        mErrs++;
        mDrop = 1'b1;
      end
    end else if (b == 8'hC0) modelClose();
    else if (b == 8'hDB) mEsc = 1'b1;
    else modelData(b);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) errSeen++;
      if (m_tvalid && m_tready) begin
        logic [8:0] got;
        got = {m_tlast, m_tdata};
        recvLog.push_back(got);
        if (expQ.size() == 0) check("model_underflow", {23'd0, got}, 32'h1FF);
        else check("model_byte", {23'd0, got}, {23'd0, expQ.pop_front()});
      end
    end
  end

  // Bytes are taken MSB-first from vec; must be entered just after a rising edge.
  task automatic applyStimulus(input string name, input logic [95:0] vec, input int n, input bit useModel);
    if (useModel)
      for (int i = 0; i < n; i++) modelByte(vec[8*(n-1-i) +: 8]);
    for (int i = 0; i < n; i++) begin
      bit acc;
      acc      = 1'b0;
      s_tdata  = vec[8*(n-1-i) +: 8];
      s_tvalid = 1'b1;
      for (int w = 0; w < 50 && !acc; w++) begin
        @(negedge clk);
        acc = s_tready;
        @(posedge clk);
        #1;
      end
      if (!acc) check({name, "_accept_timeout"}, 32'd0, 32'd1);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] dataVec, input logic [7:0] lastMask,
                             input int n, input int errs);
    repeat (4) @(posedge clk);
    #1;
    check({name, "_count"}, recvLog.size(), n);
    for (int i = 0; i < n; i++)
      if (i < recvLog.size())
        check({name, "_byte"}, {23'd0, recvLog[i]}, {23'd0, lastMask[n-1-i], dataVec[8*(n-1-i) +: 8]});
    check({name, "_frame_err"}, errSeen, errs);
    check({name, "_model_left"}, expQ.size(), 0);
`ifdef SLIP_DEFRAMER_ERR_CNT_EN
    check({name, "_err_cnt"}, {16'd0, err_cnt}, mErrs);
`endif
    recvLog.delete();
    errSeen = 0;
  endtask

  task automatic checkResetValues(input string name);
    check({name, "_m_tvalid"}, {31'd0, m_tvalid}, 32'd0);
    check({name, "_m_tdata"}, {24'd0, m_tdata}, 32'd0);
    check({name, "_m_tlast"}, {31'd0, m_tlast}, 32'd0);
    check({name, "_s_tready"}, {31'd0, s_tready}, 32'd1);
    check({name, "_frame_err"}, {31'd0, frame_err}, 32'd0);
`ifdef SLIP_DEFRAMER_ERR_CNT_EN
    check({name, "_err_cnt"}, {16'd0, err_cnt}, 32'd0);
`endif
  endtask

  initial begin
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus("basic", 96'hC0_01_02_03_C0, 5, 1'b1);
    checkOutput("basic", 64'h01_02_03, 8'b001, 3, 0);

    applyStimulus("escape", 96'h01_DB_DC_DB_DD_C0, 6, 1'b1);
    checkOutput("escape", 64'h01_C0_DB, 8'b001, 3, 0);

    applyStimulus("b2b_end", 96'hC0_C0_C0_55_C0, 5, 1'b1);
    checkOutput("b2b_end", 64'h55, 8'b1, 1, 0);

    applyStimulus("bad_esc", 96'h11_DB_22_33_C0_44_C0, 7, 1'b1);
    checkOutput("bad_esc", 64'h11_44, 8'b11, 2, 1);

    applyStimulus("too_long", 96'h01_02_03_04_05_06_C0, 7, 1'b1);
    checkOutput("too_long", 64'h01_02_03_04, 8'b0001, 4, 1);

    applyStimulus("esc_end", 96'h21_DB_C0, 3, 1'b1);
    checkOutput("esc_end", 64'h21, 8'b1, 1, 1);

    fork
      applyStimulus("stall", 96'h01_02_03_04_C0, 5, 1'b1);
      begin
        bit seen;
        seen = 1'b0;
        for (int w = 0; w < 50 && !seen; w++) begin
          @(posedge clk);
          seen = (recvLog.size() >= 1);
        end
        if (!seen) check("stall_start_timeout", 32'd0, 32'd1);
        #1;
        m_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("stall_s_tready", {31'd0, s_tready}, 32'd0);
          check("stall_m_tvalid", {31'd0, m_tvalid}, 32'd1);
          check("stall_m_tdata", {24'd0, m_tdata}, 32'h02);
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    checkOutput("stall", 64'h01_02_03_04, 8'b0001, 4, 0);

    m_tready = 1'b0;
    applyStimulus("midrst", 96'h01_02, 2, 1'b0);
    check("midrst_pre_valid", {31'd0, m_tvalid}, 32'd1);
    check("midrst_pre_data", {24'd0, m_tdata}, 32'h01);
    rst = 1'b1;
    #1;
    checkResetValues("midrst");
    mEsc  = 1'b0;
    mDrop = 1'b0;
    mErrs = 0;
    frameQ.delete();
    expQ.delete();
    recvLog.delete();
    errSeen = 0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("after_rst", 96'h77_C0, 2, 1'b1);
    checkOutput("after_rst", 64'h77, 8'b1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
